// File: rtl/riscv_pkg.sv
// Shared RV32I definitions for the execute stage.
// Holds the ALU operation codes, control-flow classes, forwarding selects,
// branch funct3 codes, and the operand-forwarding mux helper.
package riscv_pkg;

    localparam int XLEN = 32;

    // ALU operations
    localparam logic [3:0] ALU_ADD   = 4'b0000;
    localparam logic [3:0] ALU_SUB   = 4'b0001;
    localparam logic [3:0] ALU_AND   = 4'b0010;
    localparam logic [3:0] ALU_OR    = 4'b0011;
    localparam logic [3:0] ALU_XOR   = 4'b0100;
    localparam logic [3:0] ALU_SLL   = 4'b0101;
    localparam logic [3:0] ALU_SRL   = 4'b0110;
    localparam logic [3:0] ALU_SRA   = 4'b0111;
    localparam logic [3:0] ALU_SLT   = 4'b1000;
    localparam logic [3:0] ALU_SLTU  = 4'b1001;
    localparam logic [3:0] ALU_PASSB = 4'b1010;
    localparam logic [3:0] ALU_AUIPC = 4'b1011;

    // Control-flow classes
    localparam logic [2:0] NEXT_PC   = 3'b000;
    localparam logic [2:0] PC_JAL    = 3'b001;
    localparam logic [2:0] PC_JALR   = 3'b010;
    localparam logic [2:0] PC_BRANCH = 3'b011;

    // Forwarding selects (2'b11 falls back to the register value)
    localparam logic [1:0] FWD_REG = 2'b00;
    localparam logic [1:0] FWD_W   = 2'b01;
    localparam logic [1:0] FWD_M   = 2'b10;

    // Branch funct3
    localparam logic [2:0] BR_EQ  = 3'b000;
    localparam logic [2:0] BR_NE  = 3'b001;
    localparam logic [2:0] BR_LT  = 3'b100;
    localparam logic [2:0] BR_GE  = 3'b101;
    localparam logic [2:0] BR_LTU = 3'b110;
    localparam logic [2:0] BR_GEU = 3'b111;

    function automatic logic [XLEN-1:0] fwd_mux(
        input logic [1:0]      sel,
        input logic [XLEN-1:0] reg_val,
        input logic [XLEN-1:0] w_val,
        input logic [XLEN-1:0] m_val
    );
        case (sel)
            FWD_W:   return w_val;
            FWD_M:   return m_val;
            default: return reg_val;
        endcase
    endfunction

endpackage

// File: rtl/execute_stage_if.sv
// ID/EX -> EX/MEM bundle for the execute stage.
// master: the pipeline side that supplies the E fields and consumes the M fields.
// slave : the execute stage, which reads the E fields and drives the M fields.
interface execute_stage_if;
    import riscv_pkg::*;

    // ID/EX register outputs
    logic            RegWriteE;
    logic [1:0]      ResultSrcE;
    logic            MemWriteE;
    logic [2:0]      PCsrcE;
    logic [2:0]      BranchTypeE;
    logic [3:0]      ALUControlE;
    logic            ALUsrcE;
    logic [XLEN-1:0] rd1E;
    logic [XLEN-1:0] rd2E;
    logic [XLEN-1:0] pcE;
    logic [XLEN-1:0] PCPlus4E;
    logic [XLEN-1:0] ImmExtE;
    logic [4:0]      RdE;

    // EX/MEM register outputs
    logic            RegWriteM;
    logic            MemWriteM;
    logic [1:0]      ResultSrcM;
    logic [XLEN-1:0] ALUResultM;
    logic [XLEN-1:0] WriteDataM;
    logic [XLEN-1:0] PCPlus4M;
    logic [4:0]      RdM;

    modport master (
        output RegWriteE, ResultSrcE, MemWriteE, PCsrcE, BranchTypeE, ALUControlE,
               ALUsrcE, rd1E, rd2E, pcE, PCPlus4E, ImmExtE, RdE,
        input  RegWriteM, MemWriteM, ResultSrcM, ALUResultM, WriteDataM, PCPlus4M, RdM
    );

    modport slave (
        input  RegWriteE, ResultSrcE, MemWriteE, PCsrcE, BranchTypeE, ALUControlE,
               ALUsrcE, rd1E, rd2E, pcE, PCPlus4E, ImmExtE, RdE,
        output RegWriteM, MemWriteM, ResultSrcM, ALUResultM, WriteDataM, PCPlus4M, RdM
    );

endinterface

// File: rtl/execute_stage_alu.sv
// Combinational RV32I ALU.
// Ports: op (operation code), a/b (operands), pc (for AUIPC), result.
// Unused op codes return zero; arithmetic wraps modulo 2^32.
module alu
    import riscv_pkg::*;
(
    input  logic [3:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] result
);

    always_comb begin
        // NOTE: every path assigns result (default first) so no latch is inferred.
        result = '0;
        case (op)
            ALU_ADD:   result = a + b;
            ALU_SUB:   result = a - b;
            ALU_AND:   result = a & b;
            ALU_OR:    result = a | b;
            ALU_XOR:   result = a ^ b;
            ALU_SLL:   result = a << b[4:0];
            ALU_SRL:   result = a >> b[4:0];
            ALU_SRA:   result = $signed(a) >>> b[4:0];
            ALU_SLT:   result = {{(XLEN-1){1'b0}}, $signed(a) < $signed(b)};
            ALU_SLTU:  result = {{(XLEN-1){1'b0}}, a < b};
            ALU_PASSB: result = b;
            ALU_AUIPC: result = pc + b;
            default:   result = '0;
        endcase
    end

endmodule

// File: rtl/execute_stage.sv
// Execute stage of the 5-stage RV32I pipeline.
// Ports: clk, rst_n (async active-low), FlushM (bubble into EX/MEM),
//        ForwardAE/ForwardBE + ResultW (operand forwarding),
//        PCTargetE/PCSrcTakenE (same-cycle redirect to fetch),
//        bus (ID/EX fields in, EX/MEM register out).
module execute_stage
    import riscv_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  FlushM,
    input  logic [1:0]            ForwardAE,
    input  logic [1:0]            ForwardBE,
    input  logic [DATA_WIDTH-1:0] ResultW,
    output logic [DATA_WIDTH-1:0] PCTargetE,
    output logic                  PCSrcTakenE,
    execute_stage_if.slave        bus
);

    logic [DATA_WIDTH-1:0] src_a;
    logic [DATA_WIDTH-1:0] fwd_b;
    logic [DATA_WIDTH-1:0] src_b;
    logic [DATA_WIDTH-1:0] alu_result;
    logic [DATA_WIDTH-1:0] jalr_sum;
    logic                  branch_taken;

    // The M-side forward is this block's own registered ALU result.
    assign src_a = fwd_mux(ForwardAE, bus.rd1E, ResultW, bus.ALUResultM);
    assign fwd_b = fwd_mux(ForwardBE, bus.rd2E, ResultW, bus.ALUResultM);
    assign src_b = bus.ALUsrcE ? bus.ImmExtE : fwd_b;

    alu u_alu (
        .op     (bus.ALUControlE),
        .a      (src_a),
        .b      (src_b),
        .pc     (bus.pcE),
        .result (alu_result)
    );

    // Branches compare the two register operands, never the immediate.
    always_comb begin
        branch_taken = 1'b0;
        case (bus.BranchTypeE)
            BR_EQ:   branch_taken = (src_a == fwd_b);
            BR_NE:   branch_taken = (src_a != fwd_b);
            BR_LT:   branch_taken = ($signed(src_a) <  $signed(fwd_b));
            BR_GE:   branch_taken = ($signed(src_a) >= $signed(fwd_b));
            BR_LTU:  branch_taken = (src_a <  fwd_b);
            BR_GEU:  branch_taken = (src_a >= fwd_b);
            default: branch_taken = 1'b0;
        endcase
    end

    assign jalr_sum = src_a + bus.ImmExtE;

    always_comb begin
        PCTargetE   = bus.pcE + bus.ImmExtE;
        PCSrcTakenE = 1'b0;
        case (bus.PCsrcE)
            PC_JAL:    PCSrcTakenE = 1'b1;
            PC_JALR: begin
                PCSrcTakenE = 1'b1;
                PCTargetE   = {jalr_sum[DATA_WIDTH-1:1], 1'b0};
            end
            PC_BRANCH: PCSrcTakenE = branch_taken;
            default:   PCSrcTakenE = 1'b0;
        endcase
    end

    // EX/MEM register. A flush clears only the control fields; data still loads.
    // NOTE: pipeline registers take the async reset so a reset mid-stream drops
    // in-flight work; state updates use non-blocking assignments throughout.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.RegWriteM  <= 1'b0;
            bus.MemWriteM  <= 1'b0;
            bus.ResultSrcM <= 2'b00;
            bus.ALUResultM <= '0;
            bus.WriteDataM <= '0;
            bus.PCPlus4M   <= '0;
            bus.RdM        <= '0;
        end else begin
            bus.RegWriteM  <= FlushM ? 1'b0  : bus.RegWriteE;
            bus.MemWriteM  <= FlushM ? 1'b0  : bus.MemWriteE;
            bus.ResultSrcM <= FlushM ? 2'b00 : bus.ResultSrcE;
            bus.RdM        <= FlushM ? 5'd0  : bus.RdE;
            bus.ALUResultM <= alu_result;
            bus.WriteDataM <= fwd_b;
            bus.PCPlus4M   <= bus.PCPlus4E;
        end
    end

endmodule

// File: tb/tb_execute_stage.sv
// Self-checking bench for execute_stage: a table of directed vectors with
// hand-computed expectations, plus hand-written reset sequences.
module tb_execute_stage;
    import riscv_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        FlushM;
    logic [1:0]  ForwardAE;
    logic [1:0]  ForwardBE;
    logic [31:0] ResultW;
    logic [31:0] PCTargetE;
    logic        PCSrcTakenE;

    execute_stage_if bus ();

    execute_stage #(.DATA_WIDTH(32)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .FlushM      (FlushM),
        .ForwardAE   (ForwardAE),
        .ForwardBE   (ForwardBE),
        .ResultW     (ResultW),
        .PCTargetE   (PCTargetE),
        .PCSrcTakenE (PCSrcTakenE),
        .bus         (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        string       name;
        logic        regw;
        logic [1:0]  rsrc;
        logic        memw;
        logic [2:0]  pcsrc;
        logic [2:0]  btype;
        logic [3:0]  aluc;
        logic        alusrc;
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic [31:0] pc;
        logic [31:0] pc4;
        logic [31:0] imm;
        logic [4:0]  rd;
        logic [1:0]  fa;
        logic [1:0]  fb;
        logic [31:0] resw;
        logic        flush;
        logic        exp_taken;
        logic [31:0] exp_target;
        logic [31:0] exp_alu;
        logic [31:0] exp_wdata;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t blank(input string name);
        vec_t v;
        v.name = name;
        v.regw = 1'b0; v.rsrc = 2'b00; v.memw = 1'b0;
        v.pcsrc = NEXT_PC; v.btype = BR_EQ; v.aluc = ALU_ADD; v.alusrc = 1'b0;
        v.rd1 = '0; v.rd2 = '0; v.pc = '0; v.pc4 = '0; v.imm = '0; v.rd = '0;
        v.fa = FWD_REG; v.fb = FWD_REG; v.resw = '0; v.flush = 1'b0;
        v.exp_taken = 1'b0; v.exp_target = '0; v.exp_alu = '0; v.exp_wdata = '0;
        return v;
    endfunction

    task automatic drive(input vec_t v);
        bus.RegWriteE   = v.regw;
        bus.ResultSrcE  = v.rsrc;
        bus.MemWriteE   = v.memw;
        bus.PCsrcE      = v.pcsrc;
        bus.BranchTypeE = v.btype;
        bus.ALUControlE = v.aluc;
        bus.ALUsrcE     = v.alusrc;
        bus.rd1E        = v.rd1;
        bus.rd2E        = v.rd2;
        bus.pcE         = v.pc;
        bus.PCPlus4E    = v.pc4;
        bus.ImmExtE     = v.imm;
        bus.RdE         = v.rd;
        ForwardAE       = v.fa;
        ForwardBE       = v.fb;
        ResultW         = v.resw;
        FlushM          = v.flush;
    endtask

    task automatic check_m_zero(input string tag);
        check({tag, ".RegWriteM"},  {31'b0, bus.RegWriteM}, 32'd0);
        check({tag, ".MemWriteM"},  {31'b0, bus.MemWriteM}, 32'd0);
        check({tag, ".ResultSrcM"}, {30'b0, bus.ResultSrcM}, 32'd0);
        check({tag, ".ALUResultM"}, bus.ALUResultM, 32'd0);
        check({tag, ".WriteDataM"}, bus.WriteDataM, 32'd0);
        check({tag, ".PCPlus4M"},   bus.PCPlus4M, 32'd0);
        check({tag, ".RdM"},        {27'b0, bus.RdM}, 32'd0);
    endtask

    // Drive on the falling edge, check the redirect before the rising edge,
    // then check the EX/MEM register just after it.
    task automatic apply(input vec_t v);
        @(negedge clk);
        drive(v);
        #1;
        check({v.name, ".taken"},  {31'b0, PCSrcTakenE}, {31'b0, v.exp_taken});
        check({v.name, ".target"}, PCTargetE, v.exp_target);
        @(posedge clk);
        #1;
        check({v.name, ".RegWriteM"},  {31'b0, bus.RegWriteM}, {31'b0, v.flush ? 1'b0 : v.regw});
        check({v.name, ".MemWriteM"},  {31'b0, bus.MemWriteM}, {31'b0, v.flush ? 1'b0 : v.memw});
        check({v.name, ".ResultSrcM"}, {30'b0, bus.ResultSrcM}, {30'b0, v.flush ? 2'b00 : v.rsrc});
        check({v.name, ".RdM"},        {27'b0, bus.RdM}, {27'b0, v.flush ? 5'd0 : v.rd});
        check({v.name, ".ALUResultM"}, bus.ALUResultM, v.exp_alu);
        check({v.name, ".WriteDataM"}, bus.WriteDataM, v.exp_wdata);
        check({v.name, ".PCPlus4M"},   bus.PCPlus4M, v.pc4);
    endtask

    initial begin
        vec_t v;

        // Vectors run back to back; M-forwarding relies on the previous row's ALU result.
        v = blank("prime"); v.rd1 = 32'h10; v.rd2 = 32'h55; v.alusrc = 1'b1;
        v.exp_alu = 32'h10; v.exp_wdata = 32'h55; vecs.push_back(v);

        v = blank("fwdA_add"); v.rd1 = 32'd5; v.fa = FWD_M; v.imm = 32'd3; v.alusrc = 1'b1;
        v.regw = 1'b1; v.rd = 5'd3; v.exp_target = 32'd3; v.exp_alu = 32'h13; vecs.push_back(v);

        v = blank("fwdB_sltu"); v.rd2 = 32'd7; v.fb = FWD_W; v.resw = 32'hFFFF_FFFF;
        v.aluc = ALU_SLTU; v.regw = 1'b1; v.rd = 5'd4;
        v.exp_alu = 32'd1; v.exp_wdata = 32'hFFFF_FFFF; vecs.push_back(v);

        v = blank("blt"); v.pcsrc = PC_BRANCH; v.btype = BR_LT; v.aluc = ALU_SUB;
        v.rd1 = 32'hFFFF_FFFE; v.rd2 = 32'd1; v.pc = 32'h100; v.imm = 32'h20;
        v.exp_taken = 1'b1; v.exp_target = 32'h120; v.exp_alu = 32'hFFFF_FFFD; v.exp_wdata = 32'd1;
        vecs.push_back(v);

        v.name = "bltu"; v.btype = BR_LTU; v.exp_taken = 1'b0; vecs.push_back(v);

        v = blank("jalr"); v.pcsrc = PC_JALR; v.rd1 = 32'h1001; v.imm = 32'd4; v.alusrc = 1'b1;
        v.rsrc = 2'b10; v.pc4 = 32'h44; v.pc = 32'h300; v.regw = 1'b1; v.rd = 5'd1;
        v.exp_taken = 1'b1; v.exp_target = 32'h1004; v.exp_alu = 32'h1005; vecs.push_back(v);

        v = blank("flush"); v.flush = 1'b1; v.regw = 1'b1; v.memw = 1'b1; v.rd = 5'd9;
        v.rsrc = 2'b01; v.rd1 = 32'd1; v.rd2 = 32'd2; v.pc4 = 32'h88;
        v.exp_alu = 32'd3; v.exp_wdata = 32'd2; vecs.push_back(v);

        v = blank("sra"); v.aluc = ALU_SRA; v.rd1 = 32'h8000_0000; v.imm = 32'd4; v.alusrc = 1'b1;
        v.exp_target = 32'd4; v.exp_alu = 32'hF800_0000; vecs.push_back(v);

        v = blank("auipc"); v.aluc = ALU_AUIPC; v.pc = 32'h200; v.imm = 32'h1000; v.alusrc = 1'b1;
        v.exp_target = 32'h1200; v.exp_alu = 32'h1200; vecs.push_back(v);

        v = blank("jal_reserved_op"); v.pcsrc = PC_JAL; v.aluc = 4'b1100; v.rd1 = 32'h1234;
        v.pc = 32'h400; v.imm = 32'hFFFF_FFF0; v.alusrc = 1'b1;
        v.exp_taken = 1'b1; v.exp_target = 32'h3F0; v.exp_alu = 32'd0; vecs.push_back(v);

        v = blank("beq_regs_not_imm"); v.pcsrc = PC_BRANCH; v.btype = BR_EQ; v.alusrc = 1'b1;
        v.rd1 = 32'd7; v.rd2 = 32'd7; v.imm = 32'd9;
        v.exp_taken = 1'b1; v.exp_target = 32'd9; v.exp_alu = 32'd16; v.exp_wdata = 32'd7;
        vecs.push_back(v);

        v = blank("bgeu_fwdM"); v.pcsrc = PC_BRANCH; v.btype = BR_GEU; v.aluc = ALU_OR;
        v.rd1 = 32'h10; v.rd2 = 32'hFF; v.fb = FWD_M; v.pc = 32'h10; v.imm = 32'h8;
        v.exp_taken = 1'b1; v.exp_target = 32'h18; v.exp_alu = 32'h10; v.exp_wdata = 32'h10;
        vecs.push_back(v);

        v = blank("btype010_slt"); v.pcsrc = PC_BRANCH; v.btype = 3'b010; v.aluc = ALU_SLT;
        v.rd1 = 32'hFFFF_FFFF; v.rd2 = 32'd1;
        v.exp_taken = 1'b0; v.exp_target = 32'd0; v.exp_alu = 32'd1; v.exp_wdata = 32'd1;
        vecs.push_back(v);

        v = blank("passb_reserved_pc"); v.pcsrc = 3'b100; v.aluc = ALU_PASSB; v.alusrc = 1'b1;
        v.imm = 32'hABCD_0000; v.memw = 1'b1; v.rd = 5'd31; v.rsrc = 2'b01; v.rd2 = 32'hCAFE;
        v.exp_target = 32'hABCD_0000; v.exp_alu = 32'hABCD_0000; v.exp_wdata = 32'hCAFE;
        vecs.push_back(v);

        v = blank("sll_b4_0"); v.aluc = ALU_SLL; v.rd1 = 32'd1; v.rd2 = 32'h25; v.fb = 2'b11;
        v.exp_alu = 32'h20; v.exp_wdata = 32'h25; vecs.push_back(v);

        // Reset state
        rst_n = 1'b0;
        drive(blank("idle"));
        repeat (2) @(posedge clk);
        #1;
        check_m_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[i]) apply(vecs[i]);

        // Mid-cycle reset must clear M outputs before the next clock edge.
        v = blank("pre_rst"); v.regw = 1'b1; v.memw = 1'b1; v.rsrc = 2'b10; v.rd = 5'd12;
        v.rd1 = 32'h40; v.rd2 = 32'h9; v.pc4 = 32'h64; v.exp_alu = 32'h49; v.exp_wdata = 32'h9;
        apply(v);
        #2;
        rst_n = 1'b0;
        #1;
        check_m_zero("async_rst");
        @(negedge clk);
        rst_n = 1'b1;

        // First edge after reset release loads normally.
        @(posedge clk);
        #1;
        check("post_rst.RegWriteM", {31'b0, bus.RegWriteM}, 32'd1);
        check("post_rst.RdM", {27'b0, bus.RdM}, 32'd12);
        check("post_rst.ALUResultM", bus.ALUResultM, 32'h49);
        check("post_rst.PCPlus4M", bus.PCPlus4M, 32'h64);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
